// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Provides the blank pattern, the active-low hex glyph table ({g,f,e,d,c,b,a})
// and a clog2 helper that never returns less than 1 bit.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Bits needed to index n items; at least 1 so single-entry counters still have a vector.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decode.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg_c   out 7  segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed, double-buffered seven-segment driver for NUM_DIGITS hex digits.
// New values arrive through a valid/ready handshake into a pending buffer and
// are copied to the active buffer only at a frame boundary, so a frame is never torn.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking of digits above 0.
// Ports:
//   Clk        in   1             system clock
//   Reset      in   1             asynchronous, active-high reset
//   InData     in   4*NUM_DIGITS  hex nibbles, digit 0 rightmost
//   InValid    in   1             InData offered this cycle
//   InReady    out  1             pending buffer empty (registered)
//   DigitMask  in   NUM_DIGITS    1 = digit may light, 0 = forced blank
//   out7       out  7             segments {g,f,e,d,c,b,a}, active-low
//   en_out     out  NUM_DIGITS    digit anodes, active-low, one-cold or all-high
//   FrameTick  out  1             one-cycle pulse when the digit index wraps to 0
module seg_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] InData,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [NUM_DIGITS-1:0]   DigitMask,
  output logic [6:0]              out7,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    FrameTick
);

  localparam int unsigned DIG_W  = NUM_DIGITS;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = clog2(NUM_DIGITS);
  localparam int unsigned CNT_W  = clog2(SCAN_DIV);

  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [DATA_W-1:0] active_q,    active_d;
  logic [DATA_W-1:0] pending_q,   pending_d;
  logic              pend_flag_q, pend_flag_d;
  logic              in_ready_q,  in_ready_d;
  logic              tick_q,      tick_d;
  logic [6:0]        out7_q,      out7_d;
  logic [DIG_W-1:0]  en_q,        en_d;

  logic              cnt_wrap_c;
  logic              boundary_c;
  logic              accept_c;
  logic [3:0]        nibble_c;
  logic [6:0]        seg_c;
  logic              lzb_blank_c;
  logic              lit_c;

  assign cnt_wrap_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign boundary_c = cnt_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
  // pend_flag_q is never set while in_ready_q is high, so accept and swap never coincide.
  assign accept_c   = InValid && in_ready_q;
  assign nibble_c   = active_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble_c),
    .seg_c  (seg_c)
  );

`ifdef SEG_LZB_EN
  // Digit i>0 blanks when it and every digit above it in the active buffer are zero.
  logic [DIG_W-1:0] zero_above_c;
  logic             run_zero_c;
  always_comb begin
    zero_above_c = '0;
    run_zero_c   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero_c      = run_zero_c && (active_q[4*i +: 4] == 4'h0);
      zero_above_c[i] = run_zero_c;
    end
  end
  assign lzb_blank_c = (idx_q != IDX_W'(0)) && zero_above_c[idx_q];
`else
  assign lzb_blank_c = 1'b0;
`endif

  assign lit_c = DigitMask[idx_q] && !lzb_blank_c;

  // Scan counter, digit index, buffer swap, handshake and output decode.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    tick_d      = boundary_c;
    out7_d      = SEG_BLANK;
    en_d        = '1;

    if (cnt_wrap_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (boundary_c && pend_flag_q) begin
      active_d    = pending_q;
      pend_flag_d = 1'b0;
    end

    if (accept_c) begin
      pending_d   = InData;
      pend_flag_d = 1'b1;
    end

    in_ready_d = !pend_flag_d;

    if (lit_c) begin
      en_d   = ~(DIG_W'(1) << idx_q);
      out7_d = seg_c;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      in_ready_q  <= 1'b1;
      tick_q      <= 1'b0;
      out7_q      <= SEG_BLANK;
      en_q        <= '1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      in_ready_q  <= in_ready_d;
      tick_q      <= tick_d;
      out7_q      <= out7_d;
      en_q        <= en_d;
    end
  end

  assign InReady   = in_ready_q;
  assign FrameTick = tick_q;
  assign out7      = out7_q;
  assign en_out    = en_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with NUM_DIGITS=4, SCAN_DIV=4.
// A cycle-count based model predicts outputs each cycle; directed steps add literal checks.
module tb_seg_scan_display;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned FRAME = ND * SD;

  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [15:0]   InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [3:0]    DigitMask = 4'hF;
  logic [6:0]    out7;
  logic [3:0]    en_out;
  logic          FrameTick;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  seg_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .InData    (InData),
    .InValid   (InValid),
    .InReady   (InReady),
    .DigitMask (DigitMask),
    .out7      (out7),
    .en_out    (en_out),
    .FrameTick (FrameTick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cycle;
  logic [15:0] m_active, m_pend;
  logic        m_flag;
  logic [6:0]  exp_out7;
  logic [3:0]  exp_en;
  logic        exp_tick, exp_ready;

  function automatic int digit_of(input int c);
    return (c / SD) % ND;
  endfunction

  function automatic bit is_bnd(input int c);
    return (c % FRAME) == FRAME - 1;
  endfunction

  function automatic bit lit(input logic [15:0] act, input int d, input logic [3:0] mask);
    bit ok;
    ok = mask[d];
`ifdef SEG_LZB_EN
    if (d > 0 && (act >> (4 * d)) == 16'h0) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [6:0] f_seg(input logic [15:0] act, input int d, input logic [3:0] mask);
    logic [15:0] sh;
    sh = act >> (4 * d);
    return lit(act, d, mask) ? TBL[sh[3:0]] : 7'h7F;
  endfunction

  function automatic logic [3:0] f_en(input logic [15:0] act, input int d, input logic [3:0] mask);
    return lit(act, d, mask) ? 4'(~(4'b0001 << d)) : 4'hF;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_cycle   <= 0;
      m_active  <= '0;
      m_pend    <= '0;
      m_flag    <= 1'b0;
      exp_out7  <= 7'h7F;
      exp_en    <= 4'hF;
      exp_tick  <= 1'b0;
      exp_ready <= 1'b1;
    end else begin
      m_cycle  <= m_cycle + 1;
      exp_out7 <= f_seg(m_active, digit_of(m_cycle), DigitMask);
      exp_en   <= f_en(m_active, digit_of(m_cycle), DigitMask);
      exp_tick <= is_bnd(m_cycle);
      if (is_bnd(m_cycle) && m_flag) m_active <= m_pend;
      if (InValid && !m_flag) begin
        m_pend    <= InData;
        m_flag    <= 1'b1;
        exp_ready <= 1'b0;
      end else if (is_bnd(m_cycle) && m_flag) begin
        m_flag    <= 1'b0;
        exp_ready <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (started) begin
      check("out7",      32'(out7),      32'(exp_out7));
      check("en_out",    32'(en_out),    32'(exp_en));
      check("FrameTick", 32'(FrameTick), 32'(exp_tick));
      check("InReady",   32'(InReady),   32'(exp_ready));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_en(input logic [3:0] pat, input logic [6:0] seg, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (en_out == pat) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: en_out %0h never seen, required within 40 cycles", name, pat);
    end else begin
      check(name, 32'(out7), 32'(seg));
    end
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (FrameTick) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: FrameTick got none, required within 40 cycles", name);
    end
  endtask

  task automatic frame_lit(input string name, input logic [3:0] exp_set);
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge Clk);
      seen |= ~en_out;
    end
    check(name, 32'(seen), 32'(exp_set));
  endtask

  initial begin
    int cnt;
    bit rdy;

    #2 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset   = 1'b0;
    started = 1'b1;

    // First lit digit after reset is index 0 showing "0".
    @(negedge Clk);
    check("first_en",   32'(en_out), 32'h0000000E);
    check("first_out7", 32'(out7),   32'h00000040);

    // Reset asserted mid-scan takes effect immediately.
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("rst_out7",  32'(out7),    32'h7F);
    check("rst_en",    32'(en_out),  32'hF);
    check("rst_ready", 32'(InReady), 32'h1);
    check("rst_tick",  32'(FrameTick), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rel_en",   32'(en_out), 32'hE);
    check("rel_out7", 32'(out7),   32'h40);

    // FrameTick spacing.
    wait_tick("tick1");
    cnt = 0;
    do begin
      @(negedge Clk);
      cnt++;
    end while (!FrameTick && cnt < 40);
    check("tick_period", 32'(cnt), 32'd16);

    // Tear-free update with back-pressure on a second value.
    repeat (5) @(negedge Clk);
    InData  = 16'h1234;
    InValid = 1'b1;
    @(negedge Clk);
    InData = 16'hABCD;
    check("ready_low", 32'(InReady), 32'h0);
    wait_en(4'h7, 7'h40, "old_frame_d3");
    rdy = 1'b0;
    for (int i = 0; i < 40 && !rdy; i++) begin
      @(negedge Clk);
      if (InReady) rdy = 1'b1;
    end
    check("ready_rise", 32'(rdy), 32'h1);
    check("ready_with_tick", 32'(FrameTick), 32'h1);
    @(negedge Clk);
    InValid = 1'b0;
    wait_en(4'hE, 7'h19, "new_d0");
    wait_en(4'hD, 7'h30, "new_d1");
    wait_en(4'hB, 7'h24, "new_d2");
    wait_en(4'h7, 7'h79, "new_d3");
    wait_en(4'hE, 7'h21, "abcd_d0");
    wait_en(4'h7, 7'h08, "abcd_d3");

    // Mask: digits 0 and 2 forced blank.
    @(negedge Clk);
    DigitMask = 4'b1010;
    @(negedge Clk);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge Clk);
      check("mask_bit0", 32'(en_out[0]), 32'h1);
      check("mask_bit2", 32'(en_out[2]), 32'h1);
      if (en_out == 4'hF) check("mask_blank", 32'(out7), 32'h7F);
    end
    DigitMask = 4'hF;

    // Leading-zero behaviour.
    @(negedge Clk);
    InData  = 16'h0050;
    InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    wait_tick("tick_0050");
`ifdef SEG_LZB_EN
    frame_lit("lit_0050", 4'b0011);
`else
    frame_lit("lit_0050", 4'b1111);
`endif
    wait_en(4'hD, 7'h12, "d1_0050");
    wait_en(4'hE, 7'h40, "d0_0050");

    InData  = 16'h0000;
    InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    wait_tick("tick_0000");
`ifdef SEG_LZB_EN
    frame_lit("lit_0000", 4'b0001);
`else
    frame_lit("lit_0000", 4'b1111);
`endif
    wait_en(4'hE, 7'h40, "d0_0000");

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
